mem_bus_ctrl: RTL and testbench
===============================

# mem_bus_ctrl

Sequential bus controller that sits directly downstream of the MEM stage and turns its combinational access controls (`mr_ctl`, `mw_ctl`, `ior_ctl`, `iow_ctl`, `mem_addr_o`, `mem_data_o`) into handshaked transactions on the data-RAM port and the memory-mapped IO port (0xFFFF_F000–0xFFFF_FFFF). It holds the pipeline with `stall_req_o` until the access completes. It returns load data to the MEM stage's `mem_data_i` input.

## Interface
Parameters:
- `ADDR_W`, 14: RAM word-address width (64 KiB).
- `IO_WAIT`, 2: fixed IO access length in cycles (≥1).
- `TIMEOUT`, 255: maximum cycles to wait for `ram_ack_i`.

Ports:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-low, on port `rst`.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `mr_ctl`, `mw_ctl`, `ior_ctl`, `iow_ctl` in 1 each: access requests from the MEM stage. Held stable while stalled.
- `mem_addr_i` in 32: byte address from the MEM stage.
- `mem_wrdata_i` in 32: store data from the MEM stage.
- `mem_rdata_o` out 32: load data to the MEM stage.
- `stall_req_o` out 1: pipeline hold request to the stall controller.
- `ram_req_o`, `ram_we_o` out 1: RAM request and write enable.
- `ram_addr_o` out ADDR_W: word address, taken from `mem_addr_i[ADDR_W+1:2]`.
- `ram_wdata_o` out 32; `ram_rdata_i` in 32; `ram_ack_i` in 1 (single-cycle completion pulse).
- `io_sel_o`, `io_we_o` out 1; `io_addr_o` out 12 (`mem_addr_i[11:0]`); `io_wdata_o` out 32; `io_rdata_i` in 32.
- `bus_err_o` out 1: sticky error flag, cleared only by reset.

## Operation
- States: IDLE, RAM, IO, DONE.
- `req` is true when any of the four control inputs is high.
- Request decode, evaluated in IDLE only:
  - Any IO control has priority over any RAM control.
  - Within a port, a write control has priority over a read control.
- Misalignment: `mem_addr_i[1:0] != 0`, with `req` true, in IDLE.
  - No port access is made.
  - `bus_err_o` is set.
  - Read data is forced to 0.
  - The state goes to DONE.
- Transition IDLE with `req` → RAM or IO.
  - Address, write data and write enable are latched into registers.
  - The RAM and IO outputs are driven only from these registers.
- RAM state:
  - `ram_req_o` is 1.
  - When `ram_ack_i` is high: capture `ram_rdata_i` (reads only) into `rdata_q`, then go to DONE.
- RAM timeout:
  - A counter counts the cycles spent in RAM.
  - If the count reaches TIMEOUT with no ack: drop the request, set `bus_err_o`, load `rdata_q = 32'hDEAD_BEEF`, then go to DONE.
- IO state:
  - `io_sel_o` is 1 for exactly IO_WAIT cycles.
  - `io_rdata_i` is sampled on the last of those cycles, then the state goes to DONE.
- DONE state:
  - `stall_req_o` is 0, so the pipeline advances at the end of this cycle.
  - `mem_rdata_o = rdata_q`.
  - The next state is IDLE unconditionally; the controls seen in DONE belong to the completing access.
- `stall_req_o = req && (state != DONE)`. This is combinational, so the stall is raised in the same cycle the request appears.
- `mem_rdata_o` outside DONE: `rdata_q`, which holds its value between accesses.
- Stores leave `rdata_q` unchanged.

## Timing
- Values after reset, asynchronous and immediate:
  - State is IDLE.
  - `ram_req_o`, `ram_we_o`, `io_sel_o`, `io_we_o`, `bus_err_o`, `stall_req_o` are 0.
  - All address, data and `mem_rdata_o` outputs are 0.
  - The timeout counter is 0.
- RAM access with the ack in the first RAM cycle:
  - Request seen in cycle T.
  - `ram_req_o` is high in T+1.
  - DONE is T+2.
  - Total: 3 cycles.
- RAM access with the ack after k wait cycles: 3+k cycles.
- IO access: IO_WAIT+2 cycles.
- Misaligned access: 2 cycles (IDLE→DONE).
- Back-to-back accesses:
  - A new request is accepted only in the cycle after DONE (IDLE).
  - No access overlaps another.
- `ram_ack_i` outside the RAM state is ignored.
- Reset asserted mid-access: the access is abandoned with no completion, and the port strobes drop immediately.
- Timeout boundary: an ack arriving in the same cycle the counter reaches TIMEOUT wins; there is no error.

## Test plan
- RAM read with ack on the first cycle:
  - Stimulus: `mr_ctl=1`, addr 0x0000_0010, `ram_rdata_i=0x1234_5678`.
  - Required: `ram_addr_o=4` and `ram_req_o` in T+1; `stall_req_o` high in T and T+1, low in T+2; `mem_rdata_o=0x1234_5678` in T+2.
- RAM write with a 3-cycle ack delay:
  - Stimulus: `mw_ctl=1`, addr 0x20, data 0xCAFE_F00D, ack delayed 3 cycles.
  - Required: `ram_we_o=1`, `ram_wdata_o=0xCAFE_F00D`; the stall lasts 5 cycles; `rdata_q` is unchanged.
- IO read with both `ior_ctl` and `mr_ctl` high:
  - Stimulus: addr 0xFFFF_FC04, `io_rdata_i=0xA5`.
  - Required: the IO path is chosen; `ram_req_o` is never asserted; `io_addr_o=0xC04`; `io_sel_o` is high for 2 cycles; `mem_rdata_o=0xA5` in DONE.
- Misaligned load:
  - Stimulus: `mr_ctl=1`, addr 0x0000_0003.
  - Required: no RAM or IO strobe; `bus_err_o=1`; `mem_rdata_o=0` in T+1.
- RAM timeout with TIMEOUT=4:
  - Stimulus: `ram_ack_i` never asserted.
  - Required: `mem_rdata_o=0xDEAD_BEEF`; `bus_err_o` rises.
- Ack on the last allowed cycle (TIMEOUT=4):
  - Stimulus: ack on cycle 4.
  - Required: normal completion with no error.
- Reset mid-RAM-wait:
  - Stimulus: `rst` driven low while in the RAM state.
  - Required: `ram_req_o` drops immediately; all outputs return to their reset values; the next request restarts from IDLE.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// Bus controller between the MEM stage and the data-RAM / memory-mapped IO ports.
// Serialises level access controls into one handshaked transaction at a time, holding the pipeline meanwhile.
module mem_bus_ctrl #(
   parameter int ADDR_W  = 14,
   parameter int IO_WAIT = 2,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mr_ctl,
   input  logic              mw_ctl,
   input  logic              ior_ctl,
   input  logic              iow_ctl,
   input  logic [31:0]       mem_addr_i,
   input  logic [31:0]       mem_wrdata_i,
   output logic [31:0]       mem_rdata_o,
   output logic              stall_req_o,
   output logic              ram_req_o,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [31:0]       ram_wdata_o,
   input  logic [31:0]       ram_rdata_i,
   input  logic              ram_ack_i,
   output logic              io_sel_o,
   output logic              io_we_o,
   output logic [11:0]       io_addr_o,
   output logic [31:0]       io_wdata_o,
   input  logic [31:0]       io_rdata_i,
   output logic              bus_err_o
);

   localparam int CNT_MAX = (TIMEOUT > IO_WAIT) ? TIMEOUT : IO_WAIT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] RAM_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] IO_LAST  = CNT_W'(IO_WAIT - 1);
   localparam logic [31:0] TIMEOUT_DATA  = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {IDLE, RAM, IO, DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]  ram_addr_q;
   logic [11:0]        io_addr_q;
   logic [31:0]        wdata_q;
   logic [31:0]        rdata_q;
   logic               we_q;
   logic               err_q;
   logic               req;
   logic               io_req;
   logic               misalign;
   logic               ram_last;
   logic               io_last;
   logic               unused_addr;

   assign req         = mr_ctl | mw_ctl | ior_ctl | iow_ctl;
   assign io_req      = ior_ctl | iow_ctl;
   assign misalign    = |mem_addr_i[1:0];
   assign ram_last    = (cnt_q == RAM_LAST);
   assign io_last     = (cnt_q == IO_LAST);
   assign unused_addr = ^mem_addr_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Counter runs only while a port is being accessed and restarts on every entry.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (misalign)    state_d = DONE;
               else if (io_req) state_d = IO;
               else             state_d = RAM;
            end
         end
         RAM: begin
            if (ram_ack_i || ram_last) state_d = DONE;
            else                       cnt_d   = cnt_q + 1'b1;
         end
         IO: begin
            if (io_last) state_d = DONE;
            else         cnt_d   = cnt_q + 1'b1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_addr_q <= '0;
         io_addr_q  <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req && misalign) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
               end else if (req) begin
                  ram_addr_q <= mem_addr_i[ADDR_W+1:2];
                  io_addr_q  <= mem_addr_i[11:0];
                  wdata_q    <= mem_wrdata_i;
                  we_q       <= io_req ? iow_ctl : mw_ctl;
               end
            end
            // An ack on the final allowed cycle takes precedence over the timeout.
            RAM: begin
               if (ram_ack_i) begin
                  if (!we_q) rdata_q <= ram_rdata_i;
               end else if (ram_last) begin
                  err_q   <= 1'b1;
                  rdata_q <= TIMEOUT_DATA;
               end
            end
            IO: begin
               if (io_last && !we_q) rdata_q <= io_rdata_i;
            end
            default: ;
         endcase
      end
   end

   // Port strobes decode the state register so an asynchronous reset drops them at once.
   assign ram_req_o   = (state_q == RAM);
   assign ram_we_o    = ram_req_o & we_q;
   assign ram_addr_o  = ram_addr_q;
   assign ram_wdata_o = wdata_q;
   assign io_sel_o    = (state_q == IO);
   assign io_we_o     = io_sel_o & we_q;
   assign io_addr_o   = io_addr_q;
   assign io_wdata_o  = wdata_q;
   assign mem_rdata_o = rdata_q;
   assign bus_err_o   = err_q;
   assign stall_req_o = req & (state_q != DONE);

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: scoreboarded load data plus per-access strobe and timing checks.
module tb_mem_bus_ctrl;

   localparam int ADDR_W  = 14;
   localparam int IO_WAIT = 2;
   localparam int TIMEOUT = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              mr_ctl = 1'b0, mw_ctl = 1'b0, ior_ctl = 1'b0, iow_ctl = 1'b0;
   logic [31:0]       mem_addr_i = '0, mem_wrdata_i = '0;
   logic [31:0]       mem_rdata_o;
   logic              stall_req_o;
   logic              ram_req_o, ram_we_o;
   logic [ADDR_W-1:0] ram_addr_o;
   logic [31:0]       ram_wdata_o;
   logic [31:0]       ram_rdata_i = '0;
   logic              ram_ack_i = 1'b0;
   logic              io_sel_o, io_we_o;
   logic [11:0]       io_addr_o;
   logic [31:0]       io_wdata_o;
   logic [31:0]       io_rdata_i = '0;
   logic              bus_err_o;

   always #5 clk = ~clk;

   mem_bus_ctrl #(.ADDR_W(ADDR_W), .IO_WAIT(IO_WAIT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .mr_ctl(mr_ctl), .mw_ctl(mw_ctl), .ior_ctl(ior_ctl), .iow_ctl(iow_ctl),
      .mem_addr_i(mem_addr_i), .mem_wrdata_i(mem_wrdata_i), .mem_rdata_o(mem_rdata_o),
      .stall_req_o(stall_req_o),
      .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
      .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .ram_ack_i(ram_ack_i),
      .io_sel_o(io_sel_o), .io_we_o(io_we_o), .io_addr_o(io_addr_o),
      .io_wdata_o(io_wdata_o), .io_rdata_i(io_rdata_i),
      .bus_err_o(bus_err_o)
   );

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   int          r_cycles, r_stall, r_ramreq, r_iosel;
   logic [31:0] r_ram_addr, r_ram_wdata, r_io_addr, r_io_wdata;
   logic        r_ram_we, r_io_we;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One access: drive controls, act as the RAM (ack on RAM cycle ack_at, 0 = never),
   // record port activity, and compare load data against the scoreboard at DONE.
   task automatic access(input logic mr, input logic mw, input logic ior, input logic iow,
                         input logic [31:0] addr, input logic [31:0] wdata, input int ack_at);
      logic done = 1'b0;
      logic [31:0] exp;
      r_cycles = 0; r_stall = 0; r_ramreq = 0; r_iosel = 0;
      r_ram_addr = '0; r_ram_wdata = '0; r_io_addr = '0; r_io_wdata = '0;
      r_ram_we = 1'b0; r_io_we = 1'b0;
      @(negedge clk);
      mr_ctl = mr; mw_ctl = mw; ior_ctl = ior; iow_ctl = iow;
      mem_addr_i = addr; mem_wrdata_i = wdata;
      for (int c = 0; c < 40 && !done; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         ram_ack_i = 1'b0;
         if (ram_req_o) begin
            r_ramreq++;
            r_ram_addr  = 32'(ram_addr_o);
            r_ram_wdata = ram_wdata_o;
            r_ram_we    = ram_we_o;
            ram_ack_i   = (r_ramreq == ack_at);
         end
         if (io_sel_o) begin
            r_iosel++;
            r_io_addr  = 32'(io_addr_o);
            r_io_wdata = io_wdata_o;
            r_io_we    = io_we_o;
         end
         #1;
         r_cycles++;
         if (stall_req_o) r_stall++;
         else             done = 1'b1;
      end
      chk("access_completes", 32'(done), 32'd1);
      if (done) begin
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
         chk("load_data", mem_rdata_o, exp);
      end
      @(negedge clk);
      mr_ctl = 1'b0; mw_ctl = 1'b0; ior_ctl = 1'b0; iow_ctl = 1'b0;
      ram_ack_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #2;
      chk("reset_strobes", {26'd0, ram_req_o, ram_we_o, io_sel_o, io_we_o, bus_err_o, stall_req_o}, 32'd0);
      chk("reset_ram_addr", 32'(ram_addr_o), 32'd0);
      chk("reset_wdata", ram_wdata_o | io_wdata_o, 32'd0);
      chk("reset_io_addr", 32'(io_addr_o), 32'd0);
      chk("reset_rdata", mem_rdata_o, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // RAM read, ack in first RAM cycle
      ram_rdata_i = 32'h1234_5678;
      exp_q.push_back(32'h1234_5678);
      access(1, 0, 0, 0, 32'h0000_0010, 32'h0, 1);
      chk("rd_cycles", r_cycles, 3);
      chk("rd_stall", r_stall, 2);
      chk("rd_ramreq", r_ramreq, 1);
      chk("rd_ram_addr", r_ram_addr, 32'd4);
      chk("rd_we", 32'(r_ram_we), 32'd0);
      chk("rd_no_io", r_iosel, 0);

      // RAM write, ack after 3 wait cycles; load data must stay
      ram_rdata_i = 32'hFFFF_0000;
      exp_q.push_back(32'h1234_5678);
      access(0, 1, 0, 0, 32'h0000_0020, 32'hCAFE_F00D, 4);
      chk("wr_cycles", r_cycles, 6);
      chk("wr_stall", r_stall, 5);
      chk("wr_we", 32'(r_ram_we), 32'd1);
      chk("wr_wdata", r_ram_wdata, 32'hCAFE_F00D);
      chk("wr_ram_addr", r_ram_addr, 32'd8);
      chk("wr_no_err", 32'(bus_err_o), 32'd0);

      // IO read wins over RAM read
      io_rdata_i = 32'h0000_00A5;
      exp_q.push_back(32'h0000_00A5);
      access(1, 0, 1, 0, 32'hFFFF_FC04, 32'h0, 1);
      chk("io_rd_no_ram", r_ramreq, 0);
      chk("io_rd_sel_len", r_iosel, IO_WAIT);
      chk("io_rd_addr", r_io_addr, 32'h0000_0C04);
      chk("io_rd_we", 32'(r_io_we), 32'd0);
      chk("io_rd_cycles", r_cycles, IO_WAIT + 2);

      // IO write wins over IO read and RAM write
      io_rdata_i = 32'h5555_AAAA;
      exp_q.push_back(32'h0000_00A5);
      access(0, 1, 1, 1, 32'hFFFF_F008, 32'h0BEE_F123, 1);
      chk("io_wr_no_ram", r_ramreq, 0);
      chk("io_wr_we", 32'(r_io_we), 32'd1);
      chk("io_wr_wdata", r_io_wdata, 32'h0BEE_F123);
      chk("io_wr_addr", r_io_addr, 32'h0000_0008);

      // Ack on the last allowed RAM cycle completes normally
      ram_rdata_i = 32'h0BAD_CAFE;
      exp_q.push_back(32'h0BAD_CAFE);
      access(1, 0, 0, 0, 32'h0000_0040, 32'h0, TIMEOUT);
      chk("last_ack_cycles", r_cycles, TIMEOUT + 2);
      chk("last_ack_no_err", 32'(bus_err_o), 32'd0);

      // Misaligned load
      exp_q.push_back(32'h0);
      access(1, 0, 0, 0, 32'h0000_0003, 32'h0, 1);
      chk("mis_cycles", r_cycles, 2);
      chk("mis_stall", r_stall, 1);
      chk("mis_no_strobe", r_ramreq + r_iosel, 0);
      chk("mis_err", 32'(bus_err_o), 32'd1);

      // Error flag is sticky across a good access
      ram_rdata_i = 32'h1122_3344;
      exp_q.push_back(32'h1122_3344);
      access(1, 0, 0, 0, 32'h0000_0010, 32'h0, 2);
      chk("err_sticky", 32'(bus_err_o), 32'd1);

      // Reset during RAM wait
      @(negedge clk);
      mr_ctl = 1'b1; mem_addr_i = 32'h0000_0050;
      @(negedge clk);
      #1;
      chk("rst_in_ram", 32'(ram_req_o), 32'd1);
      rst = 1'b0; mr_ctl = 1'b0;
      #1;
      chk("rst_ram_req_drop", 32'(ram_req_o), 32'd0);
      chk("rst_err_clear", 32'(bus_err_o), 32'd0);
      chk("rst_rdata_clear", mem_rdata_o, 32'd0);
      chk("rst_addr_clear", 32'(ram_addr_o), 32'd0);
      chk("rst_stall", 32'(stall_req_o), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // RAM timeout after reset: fresh access from IDLE
      ram_rdata_i = 32'h7777_7777;
      exp_q.push_back(32'hDEAD_BEEF);
      access(1, 0, 0, 0, 32'h0000_0044, 32'h0, 0);
      chk("to_ramreq", r_ramreq, TIMEOUT);
      chk("to_cycles", r_cycles, TIMEOUT + 2);
      chk("to_err", 32'(bus_err_o), 32'd1);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
